fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/fetch_timeout_ctr.sv | 29 ++
 rtl/fetch_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_fetch_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;
  localparam int TMO_W       = 8;

  localparam logic [XLEN-1:0]  RESET_PC = 32'h0000_0000;
  localparam logic [TMO_W-1:0] TIMEOUT  = 8'd255;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    DRAIN = 3'd2,
    HOLD  = 3'd3,
    HALT  = 3'd4
  } fetch_state_e;

  // Instruction addresses are word aligned; low bits of a target are dropped.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return addr & ~(XLEN'(INSTR_BYTES - 1));
  endfunction

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Saturating cycle counter that flags when an instruction memory ack is overdue.
module fetch_timeout_ctr
  import fetch_pkg::*;
#(
  parameter int               W     = TMO_W,
  parameter logic [W-1:0]     LIMIT = TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (enable_i && (cnt_q != LIMIT)) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign expired_o = (cnt_q == LIMIT);

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: sequential/redirected fetch with stall hold,
// outstanding-request drain, program-end halt and ack timeout detection.
//   state | meaning
//   IDLE  | one cycle after reset, no request
//   REQ   | request at pc outstanding
//   DRAIN | waiting out an abandoned request, its data is dropped
//   HOLD  | instruction delivered, downstream stalled
//   HALT  | stopped until reset
module fetch_ctrl
  import fetch_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            finish_flag,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            inst_valid,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            halted,
  output logic            fetch_err
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] inst_q, inst_d;
  logic [XLEN-1:0] inst_pc_q, inst_pc_d;
  logic            valid_q, valid_d;
  logic            req_q, req_d;
  logic            halted_q, halted_d;
  logic            err_q, err_d;
  logic            drain_halt_q, drain_halt_d;

  logic            tmo_clr, tmo_en, tmo_expired;
  logic [XLEN-1:0] pc_seq, redir_pc;

  assign pc_seq   = pc_q + XLEN'(INSTR_BYTES);
  assign redir_pc = align_pc(redirect_target);

  fetch_timeout_ctr #(
    .W     (TMO_W),
    .LIMIT (TIMEOUT)
  ) u_tmo (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (tmo_clr),
    .enable_i  (tmo_en),
    .expired_o (tmo_expired)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    valid_d      = valid_q;
    err_d        = err_q;
    drain_halt_d = drain_halt_q;
    tmo_clr      = 1'b1;
    tmo_en       = 1'b0;

    unique case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (finish_flag) begin
          state_d = HALT;
        end else if (redirect) begin
          pc_d    = redir_pc;
          state_d = stall ? HOLD : REQ;
        end else begin
          state_d = REQ;
        end
      end

      REQ: begin
        tmo_en  = 1'b1;
        tmo_clr = imem_ack;
        if (finish_flag) begin
          valid_d = 1'b0;
          tmo_clr = 1'b1;
          if (imem_ack) begin
            state_d = HALT;
          end else begin
            state_d      = DRAIN;
            drain_halt_d = 1'b1;
          end
        end else if (redirect) begin
          // Any data arriving with or after a redirect belongs to the old path.
          valid_d = 1'b0;
          pc_d    = redir_pc;
          tmo_clr = 1'b1;
          if (!imem_ack) begin
            state_d      = DRAIN;
            drain_halt_d = 1'b0;
          end
        end else if (imem_ack) begin
          inst_d    = imem_rdata;
          inst_pc_d = pc_q;
          valid_d   = 1'b1;
          pc_d      = pc_seq;
          state_d   = stall ? HOLD : REQ;
        end else begin
          valid_d = 1'b0;
          if (tmo_expired) begin
            err_d   = 1'b1;
            state_d = HALT;
          end
        end
      end

      DRAIN: begin
        tmo_en  = 1'b1;
        tmo_clr = imem_ack;
        valid_d = 1'b0;
        if (finish_flag) begin
          drain_halt_d = 1'b1;
        end else if (redirect) begin
          pc_d = redir_pc;
        end
        if (imem_ack) begin
          state_d      = (drain_halt_q || finish_flag) ? HALT : REQ;
          drain_halt_d = 1'b0;
        end else if (tmo_expired) begin
          err_d   = 1'b1;
          state_d = HALT;
        end
      end

      HOLD: begin
        if (finish_flag) begin
          valid_d = 1'b0;
          state_d = HALT;
        end else if (redirect) begin
          valid_d = 1'b0;
          pc_d    = redir_pc;
          state_d = stall ? HOLD : REQ;
        end else if (!stall) begin
          valid_d = 1'b0;
          state_d = REQ;
        end
      end

      HALT: begin
        valid_d = 1'b0;
      end

      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase

    req_d    = (state_d == REQ);
    halted_d = (state_d == HALT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      valid_q      <= 1'b0;
      req_q        <= 1'b0;
      halted_q     <= 1'b0;
      err_q        <= 1'b0;
      drain_halt_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      valid_q      <= valid_d;
      req_q        <= req_d;
      halted_q     <= halted_d;
      err_q        <= err_d;
      drain_halt_q <= drain_halt_d;
    end
  end

  assign imem_req   = req_q;
  assign imem_addr  = pc_q;
  assign inst_valid = valid_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign halted     = halted_q;
  assign fetch_err  = err_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl.
module tb_fetch_ctrl;

  logic        clk;
  logic        reset;
  logic        finish_flag;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        halted;
  logic        fetch_err;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .finish_flag     (finish_flag),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .inst_valid      (inst_valid),
    .inst            (inst),
    .inst_pc         (inst_pc),
    .halted          (halted),
    .fetch_err       (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, tests run %0d", n_tests);
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] word(input logic [31:0] addr);
    return 32'hC0DE_0000 ^ addr;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic give_ack(input logic [31:0] addr);
    imem_ack   = 1'b1;
    imem_rdata = word(addr);
    tick();
    imem_ack   = 1'b0;
    imem_rdata = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1; finish_flag = 1'b0; stall = 1'b0; redirect = 1'b0;
    redirect_target = '0; imem_ack = 1'b0; imem_rdata = '0;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0; finish_flag = 1'b0; stall = 1'b0; redirect = 1'b0;
    redirect_target = '0; imem_ack = 1'b0; imem_rdata = '0;
    #2 reset = 1'b1;
    #1;
    n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", imem_req); end
    n_tests++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0", imem_addr); end
    n_tests++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", inst_valid); end
    n_tests++; if (inst !== 32'h0 || inst_pc !== 32'h0) begin n_fail++; $display("FAIL reset_inst: got %h/%h expected 0/0", inst, inst_pc); end
    n_tests++; if (halted !== 1'b0 || fetch_err !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got %b/%b expected 0/0", halted, fetch_err); end
    tick();
    reset = 1'b0;
    tick();
    n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL first_req: got %b@%h expected 1@00000000", imem_req, imem_addr); end
  endtask

  task automatic test_sequential();
    logic [31:0] exp;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      exp = 32'(4 * i);
      n_tests++; if (imem_req !== 1'b1 || imem_addr !== exp) begin n_fail++; $display("FAIL seq_req[%0d]: got %b@%h expected 1@%h", i, imem_req, imem_addr, exp); end
      tick();
      n_tests++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL seq_nopulse[%0d]: got %b expected 0", i, inst_valid); end
      give_ack(exp);
      n_tests++; if (inst_valid !== 1'b1) begin n_fail++; $display("FAIL seq_valid[%0d]: got %b expected 1", i, inst_valid); end
      n_tests++; if (inst_pc !== exp || inst !== word(exp)) begin n_fail++; $display("FAIL seq_inst[%0d]: got %h/%h expected %h/%h", i, inst_pc, inst, exp, word(exp)); end
    end
  endtask

  task automatic test_stall();
    do_reset();
    give_ack(32'h0);
    give_ack(32'h4);
    stall = 1'b1;
    give_ack(32'h8);
    for (int k = 0; k < 3; k++) begin
      n_tests++; if (inst_valid !== 1'b1 || imem_req !== 1'b0) begin n_fail++; $display("FAIL stall_hold[%0d]: got valid=%b req=%b expected 1/0", k, inst_valid, imem_req); end
      n_tests++; if (inst_pc !== 32'h8 || inst !== word(32'h8)) begin n_fail++; $display("FAIL stall_inst[%0d]: got %h/%h expected 00000008/%h", k, inst_pc, inst, word(32'h8)); end
      if (k < 2) tick();
    end
    stall = 1'b0;
    tick();
    n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'hC || inst_valid !== 1'b0) begin n_fail++; $display("FAIL stall_resume: got req=%b addr=%h valid=%b expected 1/0000000c/0", imem_req, imem_addr, inst_valid); end
  endtask

  task automatic test_redirect_drain();
    do_reset();
    for (int i = 0; i < 4; i++) give_ack(32'(4 * i));
    n_tests++; if (imem_addr !== 32'h10 || imem_req !== 1'b1) begin n_fail++; $display("FAIL drain_pre: got %b@%h expected 1@00000010", imem_req, imem_addr); end
    redirect = 1'b1; redirect_target = 32'h0000_0102;
    tick();
    redirect = 1'b0;
    n_tests++; if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin n_fail++; $display("FAIL drain_enter: got req=%b valid=%b expected 0/0", imem_req, inst_valid); end
    tick();
    n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL drain_wait: got %b expected 0", imem_req); end
    imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    tick();
    imem_ack = 1'b0;
    n_tests++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL drain_drop: got %b expected 0", inst_valid); end
    n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin n_fail++; $display("FAIL drain_next: got %b@%h expected 1@00000100", imem_req, imem_addr); end
    give_ack(32'h100);
    n_tests++; if (inst_valid !== 1'b1 || inst_pc !== 32'h100) begin n_fail++; $display("FAIL drain_target: got %b@%h expected 1@00000100", inst_valid, inst_pc); end
  endtask

  task automatic test_redirect_ack();
    do_reset();
    for (int i = 0; i < 8; i++) give_ack(32'(4 * i));
    n_tests++; if (imem_addr !== 32'h20) begin n_fail++; $display("FAIL redack_pre: got %h expected 00000020", imem_addr); end
    redirect = 1'b1; redirect_target = 32'h40;
    give_ack(32'h20);
    redirect = 1'b0;
    n_tests++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL redack_drop: got %b expected 0", inst_valid); end
    n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin n_fail++; $display("FAIL redack_next: got %b@%h expected 1@00000040", imem_req, imem_addr); end
    give_ack(32'h40);
    n_tests++; if (inst_valid !== 1'b1 || inst_pc !== 32'h40 || inst !== word(32'h40)) begin n_fail++; $display("FAIL redack_target: got %b@%h=%h", inst_valid, inst_pc, inst); end
  endtask

  task automatic test_finish();
    do_reset();
    give_ack(32'h0);
    finish_flag = 1'b1;
    tick();
    finish_flag = 1'b0;
    n_tests++; if (imem_req !== 1'b0 || halted !== 1'b0 || inst_valid !== 1'b0) begin n_fail++; $display("FAIL fin_drain: got req=%b halted=%b valid=%b expected 0/0/0", imem_req, halted, inst_valid); end
    tick();
    give_ack(32'h4);
    n_tests++; if (inst_valid !== 1'b0 || halted !== 1'b1 || imem_req !== 1'b0) begin n_fail++; $display("FAIL fin_halt: got valid=%b halted=%b req=%b expected 0/1/0", inst_valid, halted, imem_req); end
    for (int k = 0; k < 6; k++) begin
      imem_ack = k[0]; redirect = ~k[0]; redirect_target = 32'h200;
      tick();
      n_tests++; if (halted !== 1'b1 || imem_req !== 1'b0 || inst_valid !== 1'b0) begin n_fail++; $display("FAIL fin_stay[%0d]: got halted=%b req=%b valid=%b expected 1/0/0", k, halted, imem_req, inst_valid); end
    end
    imem_ack = 1'b0; redirect = 1'b0;
    do_reset();
    n_tests++; if (halted !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL fin_exit: got halted=%b req=%b addr=%h expected 0/1/0", halted, imem_req, imem_addr); end
  endtask

  task automatic test_timeout();
    do_reset();
    repeat (255) tick();
    n_tests++; if (fetch_err !== 1'b0 || imem_req !== 1'b1) begin n_fail++; $display("FAIL tmo_early: got err=%b req=%b expected 0/1", fetch_err, imem_req); end
    tick();
    n_tests++; if (fetch_err !== 1'b1 || halted !== 1'b1 || imem_req !== 1'b0) begin n_fail++; $display("FAIL tmo_fire: got err=%b halted=%b req=%b expected 1/1/0", fetch_err, halted, imem_req); end
    repeat (3) tick();
    n_tests++; if (fetch_err !== 1'b1) begin n_fail++; $display("FAIL tmo_sticky: got %b expected 1", fetch_err); end
  endtask

  task automatic test_async_reset();
    do_reset();
    give_ack(32'h0);
    repeat (50) tick();
    n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h4 || inst !== word(32'h0)) begin n_fail++; $display("FAIL arst_pre: got req=%b addr=%h inst=%h", imem_req, imem_addr, inst); end
    #3 reset = 1'b1;
    #1;
    n_tests++; if (imem_req !== 1'b0 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL arst_req: got %b@%h expected 0@00000000", imem_req, imem_addr); end
    n_tests++; if (inst !== 32'h0 || inst_pc !== 32'h0 || inst_valid !== 1'b0) begin n_fail++; $display("FAIL arst_inst: got %h/%h/%b expected 0/0/0", inst, inst_pc, inst_valid); end
    n_tests++; if (halted !== 1'b0 || fetch_err !== 1'b0) begin n_fail++; $display("FAIL arst_flags: got %b/%b expected 0/0", halted, fetch_err); end
    imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    tick();
    imem_ack = 1'b0;
    n_tests++; if (inst !== 32'h0 || inst_valid !== 1'b0 || imem_req !== 1'b0) begin n_fail++; $display("FAIL arst_ack_ignored: got inst=%h valid=%b req=%b", inst, inst_valid, imem_req); end
    reset = 1'b0;
    tick();
    n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL arst_restart: got %b@%h expected 1@00000000", imem_req, imem_addr); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_drain();
    test_redirect_ack();
    test_finish();
    test_timeout();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
